// File: rtl/load_store_unit.sv
// Load/store unit: turns one RISC-V style load or store into a single word-wide
// memory transaction with byte-lane steering, load extension and fault detection.
`timescale 1ns/1ps
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t      state, state_next;

    logic [31:0] addr_p0;
    logic        we_p0;
    logic [2:0]  funct3_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  wstrb_p0;

    logic        access_ok;
    logic        accept;
    logic        load_fire;

    function automatic logic is_legal(input logic st, input logic [2:0] f3);
        if (st)
            return f3 inside {3'b000, 3'b001, 3'b010};
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    // Only the size bits matter here; illegal encodings are rejected separately.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
        case (f3[1:0])
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rdata);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        shifted = rdata >> {a, 3'b000};
        b       = shifted[7:0];
        h       = shifted[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h000000, b};
            3'b101:  return {16'h0000, h};
            default: return rdata;
        endcase
    endfunction

    assign access_ok = is_legal(is_store, funct3) && !is_misaligned(funct3, addr[1:0]);
    assign accept    = (state == IDLE) && start && access_ok;
    assign load_fire = (state == REQ) && mem_ready && !we_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = access_ok ? REQ : ERR;
            REQ:  if (mem_ready) state_next = DONE;
            DONE: state_next = IDLE;
            ERR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE) || (state == ERR);
        fault     = (state == ERR);
        mem_req   = (state == REQ);
        mem_we    = (state == REQ) && we_p0;
        mem_wstrb = (state == REQ) ? wstrb_p0 : 4'b0000;
    end

    // Request stage: fields are captured once at acceptance and held for the whole REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p0   <= '0;
            we_p0     <= 1'b0;
            funct3_p0 <= '0;
            wdata_p0  <= '0;
            wstrb_p0  <= '0;
        end else if (accept) begin
            addr_p0   <= addr;
            we_p0     <= is_store;
            funct3_p0 <= funct3;
            wdata_p0  <= store_lanes(funct3, store_data);
            wstrb_p0  <= is_store ? store_strobe(funct3, addr[1:0]) : 4'b0000;
        end
    end

    assign mem_addr  = {addr_p0[31:2], 2'b00};
    assign mem_wdata = wdata_p0;

    // Result stage: only a completed load updates load_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            load_data <= '0;
        else if (load_fire)
            load_data <= load_extend(funct3_p0, addr_p0[1:0], mem_rdata);
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with directed corner cases.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, done, fault;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        bit          fault;
        logic [31:0] load;
    } resp_t;

    req_t        req_q[$];
    resp_t       done_q[$];
    logic [31:0] last_load = 32'h0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done), .fault(fault),
        .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: access size in bytes, legality and data steering from plain arithmetic.
    function automatic int size_of(input bit [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_ok(input bit st, input bit [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        return legal && ((a % size_of(f3)) == 0);
    endfunction

    function automatic logic [31:0] model_load(input bit [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int unsigned off, sz;
        logic [31:0] v;
        sz  = size_of(f3);
        off = a % 4;
        if (sz == 4) return rd;
        v = (rd >> (8 * off)) & ((32'h1 << (8 * sz)) - 1);
        if (!f3[2] && v >= (32'h1 << (8 * sz - 1)))
            v = v - (32'h1 << (8 * sz));
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input bit [2:0] f3, input logic [31:0] sd);
        case (size_of(f3))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [3:0] model_wstrb(input bit st, input bit [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        if (!st) return 4'b0000;
        sz = size_of(f3);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    // Monitor: compares presented requests and completions against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_mem_req", {31'h0, mem_req}, 32'h0);
                end else begin
                    chk("mem_we", {31'h0, mem_we}, {31'h0, req_q[0].we});
                    chk("mem_addr", mem_addr, req_q[0].addr);
                    chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, req_q[0].wstrb});
                    if (req_q[0].we) chk("mem_wdata", mem_wdata, req_q[0].wdata);
                    if (mem_ready) void'(req_q.pop_front());
                end
            end else begin
                chk("idle_we_wstrb", {27'h0, mem_we, mem_wstrb}, 32'h0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", {31'h0, done}, 32'h0);
                end else begin
                    chk("done_fault", {31'h0, fault}, {31'h0, done_q[0].fault});
                    chk("load_data", load_data, done_q[0].load);
                    void'(done_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        chk("idle_timeout", {31'h0, busy}, 32'h0);
    endtask

    task automatic scramble_inputs();
        is_store   = 1'($urandom_range(0, 1));
        funct3     = 3'($urandom_range(0, 7));
        addr       = $urandom;
        store_data = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_fault"}, {31'h0, fault}, 32'h0);
        chk({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
        chk({tag, "_mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_load_data"}, load_data, 32'h0);
    endtask

    task automatic do_access(input bit st, input bit [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rd, input int waits,
                             input bit poke_busy, input bit poke_done);
        bit    ok;
        req_t  r;
        resp_t d;
        wait_idle();
        ok = model_ok(st, f3, a);
        if (ok) begin
            r.we    = st;
            r.addr  = a & 32'hFFFF_FFFC;
            r.wdata = model_wdata(f3, sd);
            r.wstrb = model_wstrb(st, f3, a);
            req_q.push_back(r);
            if (!st) last_load = model_load(f3, a, rd);
        end
        d.fault = !ok;
        d.load  = last_load;
        done_q.push_back(d);

        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        mem_rdata = rd; mem_ready = (waits == 0);
        @(posedge clk); #1;
        start = 1'b0;
        scramble_inputs();
        if (!ok) begin
            chk("err_done", {31'h0, done}, 32'h1);
            chk("err_fault", {31'h0, fault}, 32'h1);
            chk("err_no_req", {31'h0, mem_req}, 32'h0);
        end else begin
            chk("req_latency", {31'h0, mem_req}, 32'h1);
            for (int i = 0; i < waits; i++) begin
                start = poke_busy && (i == 0);
                @(posedge clk); #1;
                start = 1'b0;
                scramble_inputs();
            end
            mem_ready = 1'b1;
            @(posedge clk); #1;
            mem_ready = 1'b0;
            chk("done_after_ready", {31'h0, done}, 32'h1);
            chk("done_no_fault", {31'h0, fault}, 32'h0);
        end
        if (poke_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_after_done", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b0; addr = '0;
        store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // LB / LBU byte 3 with sign bit set
        do_access(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_FF7F, 0, 1'b0, 1'b0);
        chk("lb_mem_addr", mem_addr, 32'h1000);
        chk("lb_value", load_data, 32'hFFFF_FF80);
        do_access(1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF_FF7F, 0, 1'b0, 1'b0);
        chk("lbu_value", load_data, 32'h0000_0080);

        // SH upper half, with wait states and pokes while busy and during done
        do_access(1'b1, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h0, 3, 1'b1, 1'b1);
        chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("sh_load_kept", load_data, 32'h0000_0080);

        // Misaligned LW
        do_access(1'b0, 3'b010, 32'h0006, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 1'b1);
        chk("err_load_kept", load_data, 32'h0000_0080);

        // Reset in the middle of a pending load
        wait_idle();
        req_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0, wstrb: 4'h0});
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40; mem_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst_req_up", {31'h0, mem_req}, 32'h1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreq_reset");
        req_q.delete();
        done_q.delete();
        last_load = 32'h0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
        chk("lw_after_reset", load_data, 32'hCAFE_F00D);

        // Randomized traffic
        for (int n = 0; n < 120; n++) begin
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(req_q.size() + done_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
